// File: rtl/relu_backward_gate.sv
// relu_backward_gate
//   Backward (gradient) half of the pipelined ReLU stage. Every accepted
//   forward pre-activation sample leaves a 1-bit derivative mask in a FIFO
//   (mask = 1 only for strictly positive samples). Returning upstream
//   gradients consume those masks in the same order, and the gated gradient
//   (mask ? grad_in : 0) comes out through a single output register.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           synchronous clear of mask FIFO and output stage
//   fwd_*           forward pre-activation stream (valid/ready/act)
//   grad_in_*       upstream gradient stream (valid/ready/data)
//   grad_out_*      gated gradient stream (valid/ready/data)
//   mask_count      number of masks currently stored
//   gated_count     saturating count of gradients zeroed since reset
module relu_backward_gate #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fwd_valid,
  output logic                    fwd_ready,
  input  logic [DATA_WIDTH-1:0]   fwd_act,
  input  logic                    grad_in_valid,
  output logic                    grad_in_ready,
  input  logic [DATA_WIDTH-1:0]   grad_in,
  output logic                    grad_out_valid,
  input  logic                    grad_out_ready,
  output logic [DATA_WIDTH-1:0]   grad_out,
  output logic [$clog2(DEPTH):0]  mask_count,
  output logic [CNT_WIDTH-1:0]    gated_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] GATED_MAX  = '1;

  logic [DEPTH-1:0]      mask_mem_q, mask_mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      mask_count_q, mask_count_d;
  logic [DATA_WIDTH-1:0] grad_out_q, grad_out_d;
  logic                  grad_out_valid_q, grad_out_valid_d;
  logic [CNT_WIDTH-1:0]  gated_count_q, gated_count_d;

  logic fwd_mask_s;
  logic pop_mask_s;
  logic push_s;
  logic pop_s;

  // Readies come from registered state only, so a pop never frees a slot
  // for a push in the same cycle and an empty FIFO is never bypassed.
  assign fwd_ready     = (mask_count_q != FULL_COUNT);
  assign grad_in_ready = (mask_count_q != '0) & (~grad_out_valid_q | grad_out_ready);

  // Zero and negative pre-activations both have a zero derivative.
  assign fwd_mask_s = ~fwd_act[DATA_WIDTH-1] & (fwd_act != '0);
  assign pop_mask_s = mask_mem_q[rd_ptr_q];

  // Handshakes seen during a flush cycle are discarded.
  assign push_s = fwd_valid & fwd_ready & ~flush;
  assign pop_s  = grad_in_valid & grad_in_ready & ~flush;

  // Next-state logic for the mask FIFO, output register and gated counter.
  always_comb begin
    mask_mem_d       = mask_mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    mask_count_d     = mask_count_q;
    grad_out_d       = grad_out_q;
    grad_out_valid_d = grad_out_valid_q;

    if (flush) begin
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
      mask_count_d     = '0;
      grad_out_d       = '0;
      grad_out_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        mask_mem_d[wr_ptr_q] = fwd_mask_s;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   mask_count_d = mask_count_q + CNT_W'(1);
        2'b01:   mask_count_d = mask_count_q - CNT_W'(1);
        default: mask_count_d = mask_count_q;
      endcase

      // grad_out keeps its value when the beat drains; only valid drops.
      if (pop_s) begin
        grad_out_d       = pop_mask_s ? grad_in : '0;
        grad_out_valid_d = 1'b1;
      end else if (grad_out_ready) begin
        grad_out_valid_d = 1'b0;
      end else begin
        grad_out_valid_d = grad_out_valid_q;
      end
    end

    // Survives flush; pop_s is already suppressed in a flush cycle.
    if (pop_s && !pop_mask_s && (gated_count_q != GATED_MAX)) begin
      gated_count_d = gated_count_q + CNT_WIDTH'(1);
    end else begin
      gated_count_d = gated_count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_mem_q       <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      mask_count_q     <= '0;
      grad_out_q       <= '0;
      grad_out_valid_q <= 1'b0;
      gated_count_q    <= '0;
    end else begin
      mask_mem_q       <= mask_mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      mask_count_q     <= mask_count_d;
      grad_out_q       <= grad_out_d;
      grad_out_valid_q <= grad_out_valid_d;
      gated_count_q    <= gated_count_d;
    end
  end

  assign mask_count     = mask_count_q;
  assign gated_count    = gated_count_q;
  assign grad_out       = grad_out_q;
  assign grad_out_valid = grad_out_valid_q;

  relu_backward_gate_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_chk (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_ready      (fwd_ready),
    .grad_in_valid  (grad_in_valid),
    .grad_in_ready  (grad_in_ready),
    .grad_out_valid (grad_out_valid_q),
    .grad_out_ready (grad_out_ready),
    .grad_out       (grad_out_q),
    .mask_count     (mask_count_q)
  );

endmodule

// relu_backward_gate_chk
//   Protocol checker: no pop from an empty FIFO, no push into a full FIFO,
//   grad_out held stable while stalled by backpressure.
module relu_backward_gate_chk #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   flush,
  input logic                   fwd_valid,
  input logic                   fwd_ready,
  input logic                   grad_in_valid,
  input logic                   grad_in_ready,
  input logic                   grad_out_valid,
  input logic                   grad_out_ready,
  input logic [DATA_WIDTH-1:0]  grad_out,
  input logic [$clog2(DEPTH):0] mask_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic                  hold_q, hold_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  // Remember whether the output beat was stalled and what it carried.
  always_comb begin
    hold_d      = grad_out_valid & ~grad_out_ready & ~flush;
    hold_data_d = grad_out;
  end

  // Stall-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Handshake and stability assertions.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(grad_in_valid && grad_in_ready) || (mask_count != '0))
        else $error("relu_backward_gate: pop with empty mask FIFO");
      assert (!(fwd_valid && fwd_ready) || (mask_count != FULL_COUNT))
        else $error("relu_backward_gate: push into full mask FIFO");
    end
    if (!rst && hold_q) begin
      assert (grad_out_valid && (grad_out == hold_data_q))
        else $error("relu_backward_gate: grad_out changed under backpressure");
    end
  end

endmodule

// File: tb/tb_relu_backward_gate.sv
// Directed bench for relu_backward_gate plus a queue-model run with random
// valid/ready, and a small-parameter instance for counter saturation.
module tb_relu_backward_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [15:0] fwd_act;
  logic        grad_in_valid;
  logic        grad_in_ready;
  logic [15:0] grad_in;
  logic        grad_out_valid;
  logic        grad_out_ready;
  logic [15:0] grad_out;
  logic [6:0]  mask_count;
  logic [15:0] gated_count;

  // small instance: DEPTH 4, 3-bit gated counter
  logic        s_fwd_valid;
  logic        s_fwd_ready;
  logic [15:0] s_fwd_act;
  logic        s_gin_valid;
  logic        s_gin_ready;
  logic [15:0] s_gin;
  logic        s_gout_valid;
  logic        s_gout_ready;
  logic [15:0] s_gout;
  logic [2:0]  s_count;
  logic [2:0]  s_gated;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  relu_backward_gate u_dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_ready      (fwd_ready),
    .fwd_act        (fwd_act),
    .grad_in_valid  (grad_in_valid),
    .grad_in_ready  (grad_in_ready),
    .grad_in        (grad_in),
    .grad_out_valid (grad_out_valid),
    .grad_out_ready (grad_out_ready),
    .grad_out       (grad_out),
    .mask_count     (mask_count),
    .gated_count    (gated_count)
  );

  relu_backward_gate #(.DATA_WIDTH(16), .DEPTH(4), .CNT_WIDTH(3)) u_sat (
    .clk            (clk),
    .rst            (rst),
    .flush          (1'b0),
    .fwd_valid      (s_fwd_valid),
    .fwd_ready      (s_fwd_ready),
    .fwd_act        (s_fwd_act),
    .grad_in_valid  (s_gin_valid),
    .grad_in_ready  (s_gin_ready),
    .grad_in        (s_gin),
    .grad_out_valid (s_gout_valid),
    .grad_out_ready (s_gout_ready),
    .grad_out       (s_gout),
    .mask_count     (s_count),
    .gated_count    (s_gated)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    flush          = 1'b0;
    fwd_valid      = 1'b0;
    fwd_act        = 16'h0000;
    grad_in_valid  = 1'b0;
    grad_in        = 16'h0000;
    grad_out_ready = 1'b1;
  endtask

  function automatic logic mask_of(input logic [15:0] a);
    return (a != 16'h0000) && !a[15];
  endfunction

  logic [15:0] t1_act  [4] = '{16'h0005, 16'hFFFD, 16'h0000, 16'h0001};
  logic [15:0] t1_grad [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
  logic [15:0] t1_exp  [4] = '{16'd10, 16'd0, 16'd0, 16'd40};

  // model state for the random run
  logic        mq[$];
  logic        m_ov;
  logic [15:0] m_out;
  int          m_gated;
  int          pushed;
  int          popped;
  logic        exp_fr, exp_gr, do_push, do_pop, m;
  int          sel;

  initial begin
    idle();
    s_fwd_valid  = 1'b0;
    s_fwd_act    = 16'h0000;
    s_gin_valid  = 1'b0;
    s_gin        = 16'h0000;
    s_gout_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state
    check_val("rst_fwd_ready", fwd_ready, 1);
    check_val("rst_gin_ready", grad_in_ready, 0);
    check_val("rst_gout_valid", grad_out_valid, 0);
    check_val("rst_gout", grad_out, 0);
    check_val("rst_count", mask_count, 0);
    check_val("rst_gated", gated_count, 0);

    // 1. mask rule and gating
    for (int i = 0; i < 4; i++) begin
      fwd_valid = 1'b1;
      fwd_act   = t1_act[i];
      tick();
    end
    fwd_valid = 1'b0;
    check_val("t1_count4", mask_count, 4);
    for (int i = 0; i < 4; i++) begin
      grad_in_valid = 1'b1;
      grad_in       = t1_grad[i];
      #1;
      check_val("t1_gin_ready", grad_in_ready, 1);
      tick();
      check_val("t1_gout_valid", grad_out_valid, 1);
      check_val("t1_gout", grad_out, t1_exp[i]);
    end
    grad_in_valid = 1'b0;
    tick();
    check_val("t1_drain_valid", grad_out_valid, 0);
    check_val("t1_gated", gated_count, 2);
    check_val("t1_count0", mask_count, 0);

    // 2. fill to DEPTH, then simultaneous pop and refused push
    fwd_valid = 1'b1;
    fwd_act   = 16'h0001;
    repeat (64) tick();
    check_val("t2_count64", mask_count, 64);
    check_val("t2_full_ready", fwd_ready, 0);
    grad_in_valid = 1'b1;
    grad_in       = 16'h0BEE;
    #1;
    check_val("t2_gin_ready", grad_in_ready, 1);
    tick();
    check_val("t2_count63", mask_count, 63);
    check_val("t2_gout", grad_out, 16'h0BEE);
    check_val("t2_ready_again", fwd_ready, 1);
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("t2_flushed", mask_count, 0);

    // 3. empty FIFO holds off gradients; push-to-pop latency
    grad_in_valid = 1'b1;
    grad_in       = 16'h1234;
    #1;
    check_val("t3_empty_ready", grad_in_ready, 0);
    fwd_valid = 1'b1;
    fwd_act   = 16'h0007;
    #1;
    check_val("t3_no_bypass", grad_in_ready, 0);
    tick();
    fwd_valid = 1'b0;
    #1;
    check_val("t3_ready_n1", grad_in_ready, 1);
    check_val("t3_valid_n1", grad_out_valid, 0);
    tick();
    grad_in_valid = 1'b0;
    check_val("t3_valid_n2", grad_out_valid, 1);
    check_val("t3_gout", grad_out, 16'h1234);
    tick();
    check_val("t3_drained", grad_out_valid, 0);

    // 4. backpressure
    fwd_valid = 1'b1;
    fwd_act = 16'h0002; tick();
    fwd_act = 16'hFFFF; tick();
    fwd_act = 16'h0003; tick();
    fwd_valid      = 1'b0;
    grad_out_ready = 1'b0;
    grad_in_valid  = 1'b1;
    grad_in        = 16'd100;
    tick();
    check_val("t4_first", grad_out, 16'd100);
    grad_in = 16'd200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t4_stall_ready", grad_in_ready, 0);
      tick();
      check_val("t4_hold_valid", grad_out_valid, 1);
      check_val("t4_hold_data", grad_out, 16'd100);
      check_val("t4_hold_count", mask_count, 2);
    end
    grad_out_ready = 1'b1;
    #1;
    check_val("t4_release_ready", grad_in_ready, 1);
    tick();
    check_val("t4_second", grad_out, 16'd0);
    grad_in = 16'd300;
    tick();
    check_val("t4_third", grad_out, 16'd300);
    grad_in_valid = 1'b0;
    tick();
    check_val("t4_drained", grad_out_valid, 0);
    check_val("t4_count", mask_count, 0);
    check_val("t4_gated", gated_count, 3);

    // 5. flush mid-stream
    fwd_valid = 1'b1;
    fwd_act = 16'h0004; tick();
    fwd_act = 16'hFFFE; tick();
    fwd_act = 16'hFFFB; tick();
    fwd_valid     = 1'b0;
    grad_in_valid = 1'b1;
    grad_in       = 16'd55;
    tick();
    check_val("t5_pop_out", grad_out, 16'd55);
    check_val("t5_count2", mask_count, 2);
    flush     = 1'b1;
    fwd_valid = 1'b1;
    fwd_act   = 16'h0009;
    #1;
    check_val("t5_pre_fwd_ready", fwd_ready, 1);
    check_val("t5_pre_gin_ready", grad_in_ready, 1);
    tick();
    idle();
    check_val("t5_count", mask_count, 0);
    check_val("t5_valid", grad_out_valid, 0);
    check_val("t5_gated", gated_count, 3);
    tick();
    check_val("t5_stays_empty", mask_count, 0);

    // 6. random valid/ready against a queue model, 200 samples
    m_ov    = 1'b0;
    m_out   = 16'h0000;
    m_gated = 3;
    pushed  = 0;
    popped  = 0;
    for (int cyc = 0; cyc < 4000 && popped < 200; cyc++) begin
      fwd_valid = (pushed < 200) && ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 4);
      case (sel)
        0:       fwd_act = 16'h8000;
        1:       fwd_act = 16'h7FFF;
        2:       fwd_act = 16'h0000;
        3:       fwd_act = 16'hFFFF;
        default: fwd_act = 16'($urandom);
      endcase
      grad_in_valid  = ($urandom_range(0, 1) == 1);
      grad_in        = 16'($urandom);
      grad_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_fr = (mq.size() != 64);
      exp_gr = (mq.size() != 0) && (!m_ov || grad_out_ready);
      check_val("t6_fwd_ready", fwd_ready, exp_fr);
      check_val("t6_gin_ready", grad_in_ready, exp_gr);
      do_push = fwd_valid && exp_fr;
      do_pop  = grad_in_valid && exp_gr;
      if (do_pop) begin
        m      = mq.pop_front();
        m_out  = m ? grad_in : 16'h0000;
        m_ov   = 1'b1;
        popped = popped + 1;
        if (!m && m_gated < 65535) m_gated = m_gated + 1;
      end else if (grad_out_ready) begin
        m_ov = 1'b0;
      end
      if (do_push) begin
        mq.push_back(mask_of(fwd_act));
        pushed = pushed + 1;
      end
      tick();
      check_val("t6_gout_valid", grad_out_valid, m_ov);
      if (m_ov) check_val("t6_gout", grad_out, m_out);
      check_val("t6_count", mask_count, mq.size());
      check_val("t6_gated", gated_count, m_gated);
    end
    check_val("t6_all_popped", popped, 200);
    idle();
    tick();

    // saturation of the gated counter on the small instance
    for (int i = 0; i < 10; i++) begin
      s_fwd_valid = 1'b1;
      s_fwd_act   = 16'hFFFF;
      tick();
      s_fwd_valid = 1'b0;
      s_gin_valid = 1'b1;
      s_gin       = 16'h00AA;
      tick();
      s_gin_valid = 1'b0;
      check_val("sat_gated", s_gated, (i + 1 > 7) ? 7 : i + 1);
      check_val("sat_gout", s_gout, 0);
    end
    s_fwd_valid = 1'b1;
    s_fwd_act   = 16'h0010;
    repeat (4) tick();
    s_fwd_valid = 1'b0;
    check_val("sat_full_count", s_count, 4);
    check_val("sat_full_ready", s_fwd_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
